// File: rtl/fixed_32_sat_acc.sv
// fixed_32_sat_acc: saturating Q24.8 vector accumulator with valid/ready result port
module fixed_32_sat_acc #(
  parameter int DATA_W     = 32,
  parameter int FRACT_BITS = 8,
  parameter int MAX_TERMS  = 16,
  parameter int CNT_W      = $clog2(MAX_TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] p_in,
  input  logic              ovf_in,
  input  logic              udf_in,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] sum_out,
  output logic              sat_flag,
  output logic              trunc_flag,
  output logic [CNT_W-1:0]  term_count,
  output logic              out_valid,
  input  logic              out_ready
);
  typedef enum logic {ACCUM, HOLD} state_t;
  localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
  state_t state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d, sum_q, sum_d, term, add;
  logic [DATA_W:0] ext;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sat_q, sat_d, trunc_q, trunc_d, pos_clamp, neg_clamp, fire, close, pop;
  assign in_ready   = state_q == ACCUM;
  assign out_valid  = state_q == HOLD;
  assign sum_out    = sum_q;
  assign sat_flag   = sat_q;
  assign trunc_flag = trunc_q;
  assign term_count = cnt_q;
  // Select the term, add with one guard bit and clamp; the close registers the result and moves to HOLD.
  always_comb begin
    term      = ovf_in ? MAX_V : udf_in ? MIN_V : p_in;
    ext       = {acc_q[DATA_W-1], acc_q} + {term[DATA_W-1], term};
    pos_clamp = ext[DATA_W:DATA_W-1] == 2'b01;
    neg_clamp = ext[DATA_W:DATA_W-1] == 2'b10;
    add       = pos_clamp ? MAX_V : neg_clamp ? MIN_V : ext[DATA_W-1:0];
    fire      = in_valid & in_ready;
    close     = fire & (in_last | (cnt_q == CNT_W'(MAX_TERMS - 1)));
    pop       = out_valid & out_ready;
    state_d   = pop ? ACCUM : close ? HOLD : state_q;
    acc_d     = pop ? '0 : fire ? add : acc_q;
    sum_d     = close ? add : sum_q;
    sat_d     = pop ? 1'b0 : fire ? (sat_q | ovf_in | udf_in | pos_clamp | neg_clamp) : sat_q;
    trunc_d   = pop ? 1'b0 : close ? ~in_last : trunc_q;
    cnt_d     = pop ? '0 : fire ? cnt_q + CNT_W'(1) : cnt_q;
  end
  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      sum_q   <= '0;
      sat_q   <= 1'b0;
      trunc_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      sat_q   <= sat_d;
      trunc_q <= trunc_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: doc/fixed_32_sat_acc.md
Name: fixed_32_sat_acc

Overview:
- Saturating Q24.8 accumulator directly downstream of the Q24.8 fixed-point multiplier.
- Consumes a stream of products plus their overflow/underflow flags and sums one vector's terms (dot product / gradient sum) into a 32-bit Q24.8 result.
- Presents the result and status flags on a valid/ready output port for the gradient-descent update logic.

Parameters:
- DATA_W, 32, operand/result width, two's complement Q24.8.
- FRACT_BITS, 8, fractional bits; informational only, no shift is performed here.
- MAX_TERMS, 16, maximum terms per vector before forced close; must be ≥2.
- CNT_W, $clog2(MAX_TERMS+1), width of term_count.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- p_in  in  DATA_W  product term, Q24.8 signed.
- ovf_in  in  1  product positively overflowed.
- udf_in  in  1  product negatively overflowed.
- in_valid  in  1  term present.
- in_last  in  1  final term of vector; qualified by in_valid.
- in_ready  out  1  block accepts a term this cycle.
- sum_out  out  DATA_W  saturated vector sum, Q24.8.
- sat_flag  out  1  sticky: any clamp occurred in this vector.
- trunc_flag  out  1  vector closed by MAX_TERMS, not by in_last.
- term_count  out  CNT_W  terms accepted in this vector.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.

Behaviour:
- Reset: one clock and one reset; reset is synchronous and active-low, sampled on rising clk while rst_n=0.
  - State ACCUM; accumulator 0; sum_out 0; sat_flag 0; trunc_flag 0; term_count 0; out_valid 0; in_ready 1.
  - Reset mid-vector or mid-HOLD discards all partial or pending results.
- State ACCUM: in_ready=1, out_valid=0.
  - Handshake fires when in_valid & in_ready.
- Term selection on handshake:
  - ovf_in=1 → term=0x7FFFFFFF.
  - else udf_in=1 → term=0x80000000.
  - else term=p_in.
  - ovf_in has priority if both flags are set.
  - Either flag being set sets sat_flag.
- Addition: sign-extend acc and term to DATA_W+1 bits and add.
  - Result > 0x7FFFFFFF → clamp to 0x7FFFFFFF and set sat_flag.
  - Result < -2^31 → clamp to 0x80000000 and set sat_flag.
  - Otherwise truncate to DATA_W. sat_flag never clears within a vector.
- term_count increments by 1 per accepted term.
- Close condition, evaluated on the handshake cycle: in_last=1, or this is term number MAX_TERMS.
  - If closed by count without in_last, trunc_flag=1.
  - If in_last coincides with term MAX_TERMS, trunc_flag=0.
- On close: register the final sum, flags and count; enter HOLD next cycle.
  - out_valid=1 one cycle after the last term is accepted (latency 1).
- State HOLD: in_ready=0; outputs stable while out_valid & !out_ready.
  - On out_valid & out_ready: next cycle out_valid=0, accumulator/sat_flag/trunc_flag/term_count=0, state ACCUM, in_ready=1.
  - No term accepted in the cycle the result is popped (no bypass).
  - sum_out retains its last value after the pop until the next close; flags clear on pop.
- No handshake while in_valid=0: accumulator unchanged, no count.
- A single-term vector (in_last on the first term) is legal: sum_out equals the selected term.
- in_last without in_valid is ignored.

Test Plan:
- Basic sum: terms 0x00000100, 0x00000280, 0xFFFFFF80 (last) → after 1 cycle out_valid=1, sum_out=0x00000300, term_count=3, sat_flag=0, trunc_flag=0.
- Positive saturation: 0x7FFFFF00 then 0x00000200 (last) → sum_out=0x7FFFFFFF, sat_flag=1; then a following vector with 0x00000100 (last) → sum_out=0x00000100, sat_flag=0.
- Flag inputs: term with udf_in=1 and p_in=0x12345678, then 0x00000100 (last) → sum_out=0x80000100, sat_flag=1. Same with ovf_in=1 and udf_in=1 → term treated as 0x7FFFFFFF.
- Backpressure: close a vector, hold out_ready=0 for 5 cycles while in_valid=1 → in_ready=0 throughout, sum_out stable, no term absorbed. Raise out_ready → pop, then in_ready=1 next cycle.
- Truncation: MAX_TERMS=16, 16 terms of 0x00000100 with in_last=0 → sum_out=0x00001000, term_count=16, trunc_flag=1. Repeat with in_last on term 16 → trunc_flag=0.
- Reset mid-operation: rst_n=0 for 1 cycle after 3 terms, and separately during HOLD → all outputs at reset values, in_ready=1. The next vector 0x00000100 (last) yields 0x00000100, term_count=1.
